// File: rtl/hub75_scan_driver.sv
// 1/16-scan HUB75 panel driver: shifts the next row pair from a synchronous-read framebuffer while the previous pair is shown.
// Optional macro HUB75_SCAN_BRIGHTNESS_EN adds a 4-bit brightness input that PWM-gates OE.
module hub75_scan_driver #(
  parameter int COLS         = 64,
  parameter int ROWS_HALF    = 16,
  parameter int DWELL_CYCLES = 256,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS_HALF),
  localparam int AW = CW + RW
) (
  input  logic          CLOCK,
  input  logic          RESET,
`ifdef HUB75_SCAN_BRIGHTNESS_EN
  input  logic [3:0]    brightness,
`endif
  output logic [AW-1:0] fb_addr,
  output logic          fb_rd,
  input  logic [2:0]    fb_data_top,
  input  logic [2:0]    fb_data_bot,
  output logic          frame_start,
  output logic [2:0]    RGB1,
  output logic [2:0]    RGB2,
  output logic [RW-1:0] addr,
  output logic          CLK,
  output logic          LAT,
  output logic          OE
);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DWELL} state_t;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d, row_nxt;
  logic          lat_cnt_q, lat_cnt_d;
  logic [15:0]   dwell_q, dwell_d;
  logic          first_q, first_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic          fb_rd_q, fb_rd_d;
  logic          fs_q, fs_d;
  logic [2:0]    rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic [RW-1:0] addr_q, addr_d;
  logic          clk_q, clk_d;
  logic          lat_q, lat_d;
  logic          oe_q, oe_d;
  logic          oe_low;
`ifdef HUB75_SCAN_BRIGHTNESS_EN
  logic [3:0]    pwm_q, pwm_d;
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      lat_cnt_q <= 1'b0;
      dwell_q   <= '0;
      first_q   <= 1'b1;
      fb_addr_q <= '0;
      fb_rd_q   <= 1'b0;
      fs_q      <= 1'b0;
      rgb1_q    <= '0;
      rgb2_q    <= '0;
      addr_q    <= '0;
      clk_q     <= 1'b0;
      lat_q     <= 1'b0;
      oe_q      <= 1'b1;
`ifdef HUB75_SCAN_BRIGHTNESS_EN
      pwm_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      col_q     <= col_d;
      row_q     <= row_d;
      lat_cnt_q <= lat_cnt_d;
      dwell_q   <= dwell_d;
      first_q   <= first_d;
      fb_addr_q <= fb_addr_d;
      fb_rd_q   <= fb_rd_d;
      fs_q      <= fs_d;
      rgb1_q    <= rgb1_d;
      rgb2_q    <= rgb2_d;
      addr_q    <= addr_d;
      clk_q     <= clk_d;
      lat_q     <= lat_d;
      oe_q      <= oe_d;
`ifdef HUB75_SCAN_BRIGHTNESS_EN
      pwm_q     <= pwm_d;
`endif
    end
  end

  // Panel outputs are registered from the next state, so each is valid for the whole
  // cycle the FSM spends in that state. CLK rises one cycle after RGB is loaded.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    col_d     = col_q;
    row_d     = row_q;
    lat_cnt_d = lat_cnt_q;
    dwell_d   = dwell_q;
    first_d   = first_q;
    fb_addr_d = fb_addr_q;
    fb_rd_d   = 1'b0;
    fs_d      = 1'b0;
    rgb1_d    = rgb1_q;
    rgb2_d    = rgb2_q;
    addr_d    = addr_q;
    clk_d     = 1'b0;
    lat_d     = 1'b0;
    oe_low    = 1'b0;
    row_nxt   = (row_q == RW'(ROWS_HALF - 1)) ? '0 : row_q + 1'b1;

    if (state_q == SHIFT && phase_q == 2'd1) begin
      rgb1_d = fb_data_top;
      rgb2_d = fb_data_bot;
    end

    case (state_q)
      IDLE: begin
        state_d   = SHIFT;
        phase_d   = 2'd0;
        col_d     = '0;
        row_d     = '0;
        fb_rd_d   = 1'b1;
        fb_addr_d = '0;
        fs_d      = 1'b1;
        oe_low    = !first_q;
      end
      SHIFT: begin
        phase_d = phase_q + 2'd1;
        oe_low  = !first_q;
        if (phase_q == 2'd2) begin
          clk_d = 1'b1;
        end else if (phase_q == 2'd3) begin
          if (col_q == CW'(COLS - 1)) begin
            col_d   = '0;
            state_d = BLANK;
            addr_d  = row_q;
            first_d = 1'b0;
            oe_low  = 1'b0;
          end else begin
            col_d     = CW'(col_q + 1'b1);
            fb_rd_d   = 1'b1;
            fb_addr_d = {row_q, CW'(col_q + 1'b1)};
          end
        end
      end
      BLANK: begin
        state_d   = LATCH;
        lat_cnt_d = 1'b0;
        lat_d     = 1'b1;
      end
      LATCH: begin
        if (!lat_cnt_q) begin
          lat_cnt_d = 1'b1;
          lat_d     = 1'b1;
        end else begin
          state_d = DWELL;
          dwell_d = '0;
          oe_low  = 1'b1;
        end
      end
      DWELL: begin
        oe_low = 1'b1;
        if (dwell_q == 16'(DWELL_CYCLES - 1)) begin
          state_d   = SHIFT;
          phase_d   = 2'd0;
          row_d     = row_nxt;
          fb_rd_d   = 1'b1;
          fb_addr_d = {row_nxt, {CW{1'b0}}};
          fs_d      = (row_nxt == '0);
          oe_low    = !first_q;
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef HUB75_SCAN_BRIGHTNESS_EN
    pwm_d = pwm_q + 4'd1;
    oe_d  = oe_low ? (pwm_d >= brightness) : 1'b1;
`else
    oe_d  = !oe_low;
`endif
  end

  assign fb_addr     = fb_addr_q;
  assign fb_rd       = fb_rd_q;
  assign frame_start = fs_q;
  assign RGB1        = rgb1_q;
  assign RGB2        = rgb2_q;
  assign addr        = addr_q;
  assign CLK         = clk_q;
  assign LAT         = lat_q;
  assign OE          = oe_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: per-cycle comparison against an arithmetic timing model of the scan sequence.
module tb_hub75_scan_driver;

  localparam int PERIOD = 515;
  localparam int FRAME  = 16 * PERIOD;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] fb_addr;
  logic       fb_rd;
  logic [2:0] fb_data_top = '0;
  logic [2:0] fb_data_bot = '0;
  logic       frame_start;
  logic [2:0] RGB1, RGB2;
  logic [3:0] addr;
  logic       CLK, LAT, OE;

  logic [2:0] fb_top [0:1023];
  logic [2:0] fb_bot [0:1023];

  int checks   = 0;
  int failures = 0;

  hub75_scan_driver dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .fb_addr(fb_addr), .fb_rd(fb_rd),
    .fb_data_top(fb_data_top), .fb_data_bot(fb_data_bot),
    .frame_start(frame_start),
    .RGB1(RGB1), .RGB2(RGB2), .addr(addr),
    .CLK(CLK), .LAT(LAT), .OE(OE)
  );

  always #10 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    if (fb_rd) begin
      fb_data_top <= fb_top[fb_addr];
      fb_data_bot <= fb_bot[fb_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pix(input int row, input int col);
    return {fb_top[row * 64 + col], fb_bot[row * 64 + col]};
  endfunction

  // Expected outputs at cycle t after reset release (t = 0 is the IDLE cycle).
  task automatic check_cycle(input int t);
    logic [5:0] e_rgb;
    int e_addr, e_fba, e_clk, e_lat, e_oe, e_rd, e_fs;
    int u, rp, o, row, col, ph, s;
    e_rgb = '0; e_addr = 0; e_fba = 0; e_clk = 0; e_lat = 0; e_oe = 1; e_rd = 0; e_fs = 0;
    if (t > 0) begin
      u = t - 1; rp = u / PERIOD; o = u % PERIOD; row = rp % 16;
      if (o < 256) begin
        col = o / 4; ph = o % 4;
        e_clk = (ph == 3) ? 1 : 0;
        e_oe  = (rp == 0) ? 1 : 0;
        e_rd  = (ph == 0) ? 1 : 0;
        e_fs  = (ph == 0 && col == 0 && row == 0) ? 1 : 0;
        e_addr = (rp == 0) ? 0 : (rp - 1) % 16;
        e_fba = row * 64 + col;
        s = (ph >= 2) ? col + 1 : col;
        if (s > 0) e_rgb = pix(row, s - 1);
        else if (rp > 0) e_rgb = pix((rp - 1) % 16, 63);
      end else begin
        e_fba  = row * 64 + 63;
        e_addr = row;
        e_rgb  = pix(row, 63);
        e_lat  = (o == 257 || o == 258) ? 1 : 0;
        e_oe   = (o < 259) ? 1 : 0;
      end
    end
    chk("RGB1", 32'(RGB1), 32'(e_rgb[5:3]));
    chk("RGB2", 32'(RGB2), 32'(e_rgb[2:0]));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("fb_addr", 32'(fb_addr), 32'(e_fba));
    chk("fb_rd", 32'(fb_rd), 32'(e_rd));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("CLK", 32'(CLK), 32'(e_clk));
    chk("LAT", 32'(LAT), 32'(e_lat));
    chk("OE", 32'(OE), 32'(e_oe));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_RGB1"}, 32'(RGB1), 0);
    chk({tag, "_RGB2"}, 32'(RGB2), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_CLK"}, 32'(CLK), 0);
    chk({tag, "_LAT"}, 32'(LAT), 0);
    chk({tag, "_OE"}, 32'(OE), 1);
    chk({tag, "_fb_rd"}, 32'(fb_rd), 0);
    chk({tag, "_fb_addr"}, 32'(fb_addr), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
  endtask

  // Runs n cycles from release, checking the model plus inter-pulse properties.
  task automatic run_cycles(input int n);
    int clk_cnt, last_fs;
    logic clk_prev, lat_prev;
    logic [3:0] addr_prev;
    clk_cnt = 0; last_fs = -1; clk_prev = 1'b0; lat_prev = 1'b0; addr_prev = addr;
    for (int t = 0; t < n; t++) begin
      if (t > 0) @(negedge CLOCK);
      else #1;
      check_cycle(t);
      if (CLK && !clk_prev) clk_cnt++;
      if (LAT && !lat_prev) begin
        chk("clk_pulses_per_lat", 32'(clk_cnt), 64);
        clk_cnt = 0;
      end
      if (frame_start) begin
        if (last_fs >= 0) chk("frame_period", 32'(t - last_fs), 32'(FRAME));
        last_fs = t;
      end
      if (addr !== addr_prev) chk("addr_change_blanked", 32'(OE), 1);
      if (t == 1)   chk("first_frame_start", 32'(frame_start), 1);
      if (t == 258) chk("first_lat_cycle", 32'(LAT), 1);
      clk_prev = CLK; lat_prev = LAT; addr_prev = addr;
    end
  endtask

  initial begin
    int t_rst;
    for (int i = 0; i < 1024; i++) begin
      fb_top[i] = '0;
      fb_bot[i] = '0;
    end
    fb_top[5] = 3'b101;
    fb_bot[5] = 3'b010;

    repeat (3) @(negedge CLOCK);
    check_reset_vals("reset");
    RESET = 1'b0;

    // Phase A: two full frames and on into row 7 of the third frame.
    t_rst = 1 + (32 + 7) * PERIOD + 30 * 4 + 2;
    fork
      run_cycles(t_rst + 1);
      begin
        @(negedge CLOCK); #1;
        repeat (19) @(negedge CLOCK);
        chk("col4_rgb1", 32'(RGB1), 0);
        repeat (4) @(negedge CLOCK);
        chk("col5_clk", 32'(CLK), 1);
        chk("col5_rgb1", 32'(RGB1), 32'(3'b101));
        chk("col5_rgb2", 32'(RGB2), 32'(3'b010));
        repeat (4) @(negedge CLOCK);
        chk("col6_rgb1", 32'(RGB1), 0);
        chk("col6_rgb2", 32'(RGB2), 0);
      end
    join

    // Mid-shift reset (row 7, col 30): outputs must clear before any clock edge.
    chk("pre_reset_addr", 32'(fb_addr), 32'(7 * 64 + 30));
    RESET = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge CLOCK);
    check_reset_vals("midrst_hold");

    for (int i = 0; i < 1024; i++) begin
      fb_top[i] = 3'($urandom);
      fb_bot[i] = 3'($urandom);
    end
    RESET = 1'b0;

    // Phase B: random framebuffer, one frame plus the start of the next.
    run_cycles(FRAME + 600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hub75_scan_driver.md
Name: hub75_scan_driver

Overview:
- Downstream stage after the text/scroll composer. Reads a 64x32 single-bit-per-colour framebuffer through a synchronous read port and drives a 1/16-scan HUB75 panel.
- Panel signals driven: RGB1, RGB2, addr, CLK, LAT, OE.
- Shifts the next row pair while the previous row pair is displayed; then blanks, re-addresses and latches.
- The composer only writes pixels; it does no panel timing.

Parameters:
- COLS, 64, columns per row; must be a power of two.
- ROWS_HALF, 16, row pairs; addr width is log2(ROWS_HALF).
- DWELL_CYCLES, 256, extra display cycles per row after shifting completes; legal range 1..65535.

Ports:
- CLOCK  in  1  system clock (50 MHz)
- RESET  in  1  asynchronous, active-high reset
- fb_addr  out  log2(ROWS_HALF)+log2(COLS) (10)  framebuffer read address = row*COLS + col
- fb_rd  out  1  read strobe; data returns exactly 1 cycle later
- fb_data_top  in  3  {R,G,B} for panel row `row`
- fb_data_bot  in  3  {R,G,B} for panel row `row+ROWS_HALF`
- frame_start  out  1  one-cycle pulse when the column-0 read of row 0 is issued
- RGB1  out  3  top-half pixel data
- RGB2  out  3  bottom-half pixel data
- addr  out  log2(ROWS_HALF) (4)  panel row select
- CLK  out  1  panel shift clock; data sampled on rising edge
- LAT  out  1  panel latch, active-high
- OE  out  1  panel output enable, active-low (1 = blank)

Behaviour:
- One clock, CLOCK. RESET is asynchronous and active-high.
- Reset values:
  - RGB1 = RGB2 = 0, addr = 0, CLK = 0, LAT = 0, OE = 1.
  - fb_rd = 0, fb_addr = 0, frame_start = 0.
  - Internal row = 0, col = 0, state = IDLE.
- Reset asserted mid-operation forces all reset values immediately. No partial row is latched.
- States: IDLE -> SHIFT -> BLANK -> LATCH -> DWELL -> SHIFT ...
- IDLE:
  - Lasts 1 cycle after reset release. OE stays 1.
  - Next state SHIFT with row = 0, col = 0.
- SHIFT: 4 phases per column, 4*COLS cycles total.
  - Phase 0: fb_rd = 1, fb_addr = row*COLS + col.
  - Phase 1: fb_rd = 0; RGB1 <= fb_data_top, RGB2 <= fb_data_bot.
  - Phase 2: CLK = 1.
  - Phase 3: CLK = 0; col increments.
  - Data is stable for at least 1 cycle before and 1 cycle after each CLK rising edge.
  - After phase 3 of col = COLS-1: col wraps to 0; next state BLANK.
  - OE = 0 during SHIFT except for the very first row after reset, where OE stays 1 because nothing is latched yet.
- BLANK:
  - 1 cycle, OE = 1.
  - addr <= row. This is the row just shifted, so addr never changes while OE = 0.
- LATCH: 2 cycles, LAT = 1, OE = 1.
- DWELL:
  - OE = 0 for DWELL_CYCLES cycles.
  - Then row <= row+1, wrapping ROWS_HALF-1 -> 0; next state SHIFT.
- Row-pair period = 4*COLS + 1 + 2 + DWELL_CYCLES. Default: 515 cycles; frame = 8240 cycles.
- Timing guarantees:
  - CLK and LAT are never both 1.
  - LAT is only 1 while OE = 1.
  - RGB outputs hold their last value outside SHIFT.
- frame_start is coincident with fb_rd for row 0, col 0 on every frame, including the first after reset.
- fb_addr is held between reads.
- Counter widths:
  - col: log2(COLS) bits.
  - dwell counter: 16 bits, compared with DWELL_CYCLES-1.

Optional Feature:
- Macro: HUB75_SCAN_BRIGHTNESS_EN.
- When defined:
  - Adds input `brightness [3:0]` and a free-running 4-bit counter pwm_cnt, reset 0, incrementing every cycle.
  - Wherever OE would be 0, OE = (pwm_cnt < brightness) ? 0 : 1.
  - brightness = 0 keeps the panel dark; brightness = 15 gives 15/16 duty.
  - brightness is sampled every cycle; no glitch on LAT/addr ordering.
- When undefined: no brightness port; OE follows the state machine only.

Test Plan:
- Reset release, framebuffer all-zero -> OE = 1 through the first SHIFT (257 cycles incl. IDLE). First LAT rising edge at cycle 258 after release. frame_start pulses at cycle 1.
- Framebuffer row 0 col 5 top = 3'b101, row 16 col 5 = 3'b010 -> on the 6th CLK rising edge of row 0, RGB1 = 101 and RGB2 = 010. Neighbouring columns = 000.
- Run two full frames -> frame_start period = 8240 cycles. addr sequence 0..15, wrapping to 0. addr changes only while OE = 1.
- Check every cycle -> never (LAT & CLK); never (LAT & !OE); exactly 64 CLK pulses between consecutive LAT pulses.
- Assert RESET mid-SHIFT of row 7, col 30 -> outputs reset asynchronously, same cycle. After release, the next fb_addr read is 0 and frame_start pulses.
- With HUB75_SCAN_BRIGHTNESS_EN, brightness = 4 -> during DWELL, OE = 0 for exactly 4 of every 16 cycles. brightness = 0 -> OE = 1 throughout.
